// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sha256_pkg
// Description : Shared SHA-256 constants for the round sequencer: the 64-entry
//               round-constant table, the initial hash value, the padding
//               tail for a 256-bit message and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

  // Round constants K[0..63]
  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Value Kt takes out of reset (K[0])
  localparam logic [31:0] K_RESET = 32'h428a2f98;

  // SHA-256 initial hash value H(0), word a in the top bits
  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Padding tail appended to a 256-bit digest to form one full block:
  // the 0x80 marker, zero fill and the 64-bit length field (256 bits)
  localparam logic [255:0] PAD_256 = {32'h80000000, 160'b0, 64'h100};

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  // Final round index of a pass
  localparam logic [5:0] LAST_ROUND = 6'd63;

endpackage : sha256_pkg
`default_nettype wire

// File: rtl/sha256_k_rom.sv
`default_nettype none
// ============================================================================
// Module      : sha256_k_rom
// Description : Combinational round-constant lookup, 6-bit round index to the
//               32-bit SHA-256 constant K[idx].
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  idx,
  output logic [31:0] k
);

  // Direct table lookup; the caller registers the result
  always_comb begin
    k = K_TABLE[idx];
  end

endmodule : sha256_k_rom
`default_nettype wire

// File: rtl/sha_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sha_round_ctrl
// Description : Round sequencer for a bank of sha_unit instances sharing one
//               round bus. Latches a block and initial hash on start, walks
//               round/Kt through 0..63 per pass, captures the unit digest and
//               optionally re-hashes the padded digest (SHA-256d) before
//               pulsing done with the final result.
// Revision    : 1.0 - initial release
// ============================================================================
module sha_round_ctrl
  import sha256_pkg::*;
#(
  parameter int PASSES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [511:0] M_in,
  input  logic [255:0] H0_in,
  input  logic [255:0] H1,
  output logic [5:0]   round,
  output logic [31:0]  Kt,
  output logic [511:0] M,
  output logic [255:0] H0,
  output logic         busy,
  output logic         done,
  output logic [255:0] result
);

  state_e         state_q, state_d;
  logic [5:0]     round_q, round_d;
  logic [31:0]    kt_q, kt_d;
  logic           pass_q, pass_d;
  logic [511:0]   msg_q, msg_d;
  logic [255:0]   h0_q, h0_d;
  logic [255:0]   dig_q, dig_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [255:0]   result_q, result_d;

  logic [31:0]    k_rom;
  logic           more_passes;

  // Another pass remains after the one currently finishing
  always_comb begin
    more_passes = (int'(pass_q) < (PASSES - 1));
  end

  // Constant for the round that will be on the bus next cycle, so round and
  // Kt update together from the same edge
  sha256_k_rom u_k_rom (
    .idx (round_d),
    .k   (k_rom)
  );

  // Kt follows the next round index through the ROM
  always_comb begin
    kt_d = k_rom;
  end

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      round_q  <= 6'd0;
      kt_q     <= K_RESET;
      pass_q   <= 1'b0;
      msg_q    <= '0;
      h0_q     <= '0;
      dig_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      kt_q     <= kt_d;
      pass_q   <= pass_d;
      msg_q    <= msg_d;
      h0_q     <= h0_d;
      dig_q    <= dig_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (round_q == LAST_ROUND) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_d = more_passes ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath and output next values for each state
  always_comb begin
    round_d  = round_q;
    pass_d   = pass_q;
    msg_d    = msg_q;
    h0_d     = h0_q;
    dig_d    = dig_q;
    result_d = result_q;
    done_d   = 1'b0;
    // Busy covers every cycle spent outside IDLE, so it drops on the same
    // edge that raises done
    busy_d   = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          msg_d   = M_in;
          h0_d    = H0_in;
          pass_d  = 1'b0;
          round_d = 6'd0;
        end
      end
      ST_RUN: begin
        // Round 63 is held through CAPTURE rather than wrapping to 0
        if (round_q != LAST_ROUND) begin
          round_d = round_q + 6'd1;
        end
      end
      ST_CAPTURE: begin
        if (more_passes) begin
          dig_d   = H1;
          pass_d  = pass_q + 1'b1;
          round_d = 6'd0;
        end else begin
          result_d = H1;
          done_d   = 1'b1;
        end
      end
      default: begin
        round_d = 6'd0;
      end
    endcase
  end

  // Block and initial hash presented to the units: the latched job on the
  // first pass, the padded first-pass digest under the standard IV after
  always_comb begin
    if (pass_q) begin
      M  = {dig_q, PAD_256};
      H0 = SHA256_IV;
    end else begin
      M  = msg_q;
      H0 = h0_q;
    end
  end

  // Registered outputs
  always_comb begin
    round  = round_q;
    Kt     = kt_q;
    busy   = busy_q;
    done   = done_q;
    result = result_q;
  end

endmodule : sha_round_ctrl
`default_nettype wire

// File: tb/tb_sha_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha_round_ctrl
// Description : Directed self-checking bench for sha_round_ctrl. A behavioural
//               SHA-256 compression stands in for sha_unit on each instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha_round_ctrl;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] ABC     = {32'h61626380, 448'b0, 32'h00000018};
  localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_D   = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start1 = 1'b0;
  logic         start2 = 1'b0;
  logic [511:0] M_in = '0;
  logic [255:0] H0_in = '0;

  logic [255:0] h1_1, h1_2, res1, res2, hz1, hz2;
  logic [511:0] m1, m2;
  logic [31:0]  kt1, kt2;
  logic [5:0]   rnd1, rnd2;
  logic         busy1, busy2, done1, done2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [511:0] blk, input logic [255:0] hin);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KT[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Behavioural stand-in for sha_unit on each controller
  always_comb h1_1 = sha_compress(m1, hz1);
  always_comb h1_2 = sha_compress(m2, hz2);

  sha_round_ctrl #(.PASSES(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .M_in(M_in), .H0_in(H0_in), .H1(h1_1),
    .round(rnd1), .Kt(kt1), .M(m1), .H0(hz1), .busy(busy1), .done(done1), .result(res1)
  );

  sha_round_ctrl #(.PASSES(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .M_in(M_in), .H0_in(H0_in), .H1(h1_2),
    .round(rnd2), .Kt(kt2), .M(m2), .H0(hz2), .busy(busy2), .done(done2), .result(res2)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_round"},  512'(rnd2),  512'(0));
    check({tag, "_kt"},     512'(kt2),   512'(32'h428a2f98));
    check({tag, "_busy"},   512'(busy2), 512'(0));
    check({tag, "_done"},   512'(done2), 512'(0));
    check({tag, "_result"}, 512'(res2),  512'(0));
    check({tag, "_m"},      m2,          512'(0));
    check({tag, "_h0"},     512'(hz2),   512'(0));
  endtask

  // One SHA-256d job on the two-pass instance. glitch_at pulses start with a
  // different block at that edge count; abort_at applies reset at that edge
  // count and then watches that no done appears.
  task automatic run_job2(input string tag, input int glitch_at, input int abort_at);
    int k;
    int stray;
    start2 = 1'b1; M_in = ABC; H0_in = IV;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int n = 0; n < 130; n++) begin
      k = n % 65;
      check({tag, "_round"}, 512'(rnd2),  512'((k < 64) ? k : 63));
      check({tag, "_kt"},    512'(kt2),   512'(KT[(k < 64) ? k : 63]));
      check({tag, "_busy"},  512'(busy2), 512'(1));
      check({tag, "_nodone"}, 512'(done2), 512'(0));
      if (n == 5) begin
        check({tag, "_m_pass0"},  m2,         ABC);
        check({tag, "_h0_pass0"}, 512'(hz2),  512'(IV));
      end
      if (n == 70) begin
        check({tag, "_m_pass1"},  m2,         {DIG_ABC, 32'h80000000, 160'b0, 64'h100});
        check({tag, "_h0_pass1"}, 512'(hz2),  512'(IV));
      end
      if (n == abort_at) begin
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check_reset_state({tag, "_abort"});
        stray = 0;
        for (int i = 0; i < 200; i++) begin
          @(posedge clk); #1;
          if (done2 || busy2) stray++;
        end
        check({tag, "_no_done_after_abort"}, 512'(stray), 512'(0));
        return;
      end
      if (n == glitch_at) begin
        start2 = 1'b1; M_in = ~ABC; H0_in = '0;
      end else begin
        start2 = 1'b0; M_in = ABC; H0_in = IV;
      end
      @(posedge clk); #1;
    end
    start2 = 1'b0;
    check({tag, "_done"},   512'(done2), 512'(1));
    check({tag, "_result"}, 512'(res2),  512'(DIG_D));
    check({tag, "_busy_low"}, 512'(busy2), 512'(0));
  endtask

  initial begin
    int lat;
    bit seen;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    check("reset_p1_round", 512'(rnd1), 512'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single pass on the PASSES=1 instance
    start1 = 1'b1; M_in = ABC; H0_in = IV;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = 0; seen = 1'b0;
    for (int n = 1; n <= 200 && !seen; n++) begin
      @(posedge clk); #1;
      if (done1) begin
        seen = 1'b1;
        lat = n;
      end
    end
    check("p1_latency", 512'(lat), 512'(65));
    check("p1_result",  512'(res1), 512'(DIG_ABC));
    check("p1_busy_low", 512'(busy1), 512'(0));
    repeat (3) @(posedge clk);
    #1;
    check("p1_done_pulse", 512'(done1), 512'(0));
    check("p1_result_hold", 512'(res1), 512'(DIG_ABC));

    // Double pass with bus alignment, then start-while-busy, then a
    // back-to-back job issued in the done cycle
    run_job2("dbl", -1, -1);
    repeat (2) @(posedge clk);
    #1;
    check("dbl_result_hold", 512'(res2), 512'(DIG_D));
    run_job2("glitch", 30, -1);
    run_job2("b2b", -1, -1);

    // Reset in pass 1 at round 10, then a clean job
    run_job2("abort", -1, 75);
    run_job2("after_abort", -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sha_round_ctrl
`default_nettype wire

// File: doc/sha_round_ctrl.md
# sha_round_ctrl

Round sequencer and initiator for one or more `sha_unit` instances that share a round bus. It latches a 512-bit block and an initial hash on `start`, then drives the shared `round`/`Kt` bus for 64 cycles. It captures `H1` and optionally runs a second pass over the padded digest (double SHA-256) before pulsing `done` with the result. It sits between the job/nonce logic and the `sha_unit` array.

## Interface
- `PASSES`, default 2: number of hash passes. Legal values are 1 (single SHA-256) and 2 (SHA-256d).
- `clk`  in  1  — system clock.
- `reset_n`  in  1  — reset. One clock; reset is synchronous and active-low.
- `start`  in  1  — request a job. Accepted only in IDLE.
- `M_in`  in  512  — message block, latched on accepted `start`.
- `H0_in`  in  256  — initial hash for pass 0, latched on accepted `start`.
- `H1`  in  256  — digest returned by `sha_unit`.
- `round`  out  6  — shared round index.
- `Kt`  out  32  — shared round constant, aligned with `round`.
- `M`  out  512  — block presented to `sha_unit`.
- `H0`  out  256  — initial hash presented to `sha_unit`.
- `busy`  out  1  — high from accepted `start` until `done`.
- `done`  out  1  — one-cycle pulse; `result` is valid in that cycle.
- `result`  out  256  — final digest, held until the next `done`.

## Operation
- States: IDLE, RUN, CAPTURE.
- **IDLE**
  - `start` = 1 latches `M_in` into `msg_q` and `H0_in` into `h0_q`.
  - Clears `pass`, sets `round` = 0 and `Kt` = K[0], then goes to RUN.
- **RUN**
  - Each cycle: `round` <= `round` + 1 and `Kt` <= K[`round` + 1].
  - At `round` = 63: go to CAPTURE. `round` holds 63 and `Kt` holds K[63].
- **CAPTURE**
  - If `pass` < `PASSES` − 1: latch `H1` into `dig_q`, increment `pass`, set `round` = 0 and `Kt` = K[0], return to RUN.
  - Otherwise: `result` <= `H1`, `done` <= 1, go to IDLE.
- `M`/`H0` are a combinational mux on `pass`:
  - `pass` = 0: `msg_q` / `h0_q`.
  - `pass` = 1: {`dig_q`, 32'h80000000, 160'b0, 64'h100} / SHA-256 IV.
- `busy` is registered and high in RUN and CAPTURE.
- `start` while `busy`: ignored. No queueing and no effect on latched data.
- `start` in the cycle `done` is high: state is already IDLE, so it is accepted (back-to-back jobs).
- `reset_n` low mid-job: next edge forces IDLE and all outputs to reset values. No `done` is produced for the aborted job.
- `round` is 6-bit and never wraps inside RUN; the transition to CAPTURE occurs at 63.
- Reset values: `round` 0, `Kt` 32'h428a2f98, `busy` 0, `done` 0, `result` 0. `msg_q`, `h0_q`, `dig_q` and `pass` reset to 0, so `M` = 0 and `H0` = 0 at reset.

## Timing
- Edge 0: `start` accepted; `round` = 0 visible after edge 0.
- Edges 1..64: `sha_unit` consumes rounds 0..63 of a pass.
- Each pass costs 65 edges: 64 rounds plus 1 capture.
- `done` is high in the cycle after edge 65·`PASSES` (edge 65 for `PASSES` = 1, edge 130 for `PASSES` = 2).
- `busy` rises after edge 0 and falls with `done` rising.
- Minimum start-to-start interval is 65·`PASSES` cycles.
- `Kt` is registered. `round` and `Kt` change on the same edge, with zero skew between them.

## Structure
- Shared package `sha256_pkg`: the 64-entry K table, the SHA-256 IV (6a09e667 … 5be0cd19), the 256-bit-message padding constant, and the state enum.
- Sub-module `sha256_k_rom`: a combinational 6-bit-index → 32-bit K lookup. The controller registers its output into `Kt`.
- `sha_round_ctrl` instantiates no `sha_unit`; the top level wires one or more units to its bus.

## Test plan
- **Single pass, "abc".** `PASSES` = 1, block 61626380_0…0_00000018, IV, with a real `sha_unit` → `done` after edge 65, `result` = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- **Double pass, "abc".** `PASSES` = 2, same block → `done` after edge 130, `result` = 4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358. During pass 1, `M` = {pass-0 digest, 80000000, 0…, 100}.
- **Bus alignment.** Check every RUN cycle: `Kt` == K[`round`], `round` steps 0..63 with no gaps, and `busy` = 1 throughout.
- **Start while busy.** Pulse `start` with a different `M_in` at `round` = 30 → ignored; `result` still matches the original block.
- **Back-to-back.** Assert `start` during the `done` cycle → the second job is accepted, and its `done` follows exactly 65·`PASSES` cycles later.
- **Reset mid-job.** Drive `reset_n` = 0 for 1 cycle at pass 1, `round` = 10 → outputs return to reset values, no `done`. A subsequent job completes correctly.
